// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the SRAM responder.
// Optional power-up clear sweep is enabled by defining SRAM_RESP_INIT_EN.
package sram_resp_pkg;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned DQ_W    = 16;
    localparam int unsigned LAT_W   = 3;
    localparam int unsigned LANE_W  = 8;
    localparam int unsigned LANE_LO = 0;
    localparam int unsigned LANE_HI = 1;
    localparam int unsigned LANES   = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RD_WAIT  = 2'd1,
        ST_RD_DRIVE = 2'd2
`ifdef SRAM_RESP_INIT_EN
        , ST_INIT   = 2'd3
`endif
    } state_e;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'd0,
        CMD_READ  = 2'd1,
        CMD_WRITE = 2'd2
    } cmd_e;

    // Bus command decode; WE_N low wins over OE_N so a clashing cycle is a write.
    function automatic cmd_e decode_cmd(input logic ce_n, input logic we_n, input logic oe_n);
        if (!ce_n && !we_n) return CMD_WRITE;
        if (!ce_n && !oe_n) return CMD_READ;
        return CMD_IDLE;
    endfunction

endpackage

// File: rtl/sram_responder_if.sv
// Address and control strobes of the asynchronous SRAM bus.
interface sram_responder_if #(
    parameter int unsigned ADDR_BITS = 18
);
    logic [ADDR_BITS-1:0] SRAM_ADDR;
    logic                 SRAM_UB_N;
    logic                 SRAM_LB_N;
    logic                 SRAM_WE_N;
    logic                 SRAM_CE_N;
    logic                 SRAM_OE_N;

    modport master (
        output SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
    );

    modport slave (
        input SRAM_ADDR, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N
    );
endinterface

// File: rtl/sram_resp_array.sv
// Word storage: one byte-enabled synchronous write port, one asynchronous read port.
module sram_resp_array
    import sram_resp_pkg::*;
#(
    parameter int unsigned MEM_BITS = 12
) (
    input  logic                clk,
    input  logic                we,
    input  logic [LANES-1:0]    be,
    input  logic [MEM_BITS-1:0] waddr,
    input  logic [DQ_W-1:0]     wdata,
    input  logic [MEM_BITS-1:0] raddr,
    output logic [DQ_W-1:0]     rdata_c
);
    localparam int unsigned DEPTH = 1 << MEM_BITS;

    logic [DQ_W-1:0] mem [DEPTH];

    // Byte-lane write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            if (be[LANE_HI]) mem[waddr][LANE_HI*LANE_W +: LANE_W] <= wdata[LANE_HI*LANE_W +: LANE_W];
            if (be[LANE_LO]) mem[waddr][LANE_LO*LANE_W +: LANE_W] <= wdata[LANE_LO*LANE_W +: LANE_W];
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/sram_responder.sv
// Behavioural responder for an asynchronous 16-bit SRAM bus, sampled on clk.
// Define SRAM_RESP_INIT_EN to add a zero-fill sweep after reset release.
module sram_responder
    import sram_resp_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 18,
    parameter int unsigned MEM_BITS    = 12,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    sram_responder_if.slave  bus,
    inout  wire  [DQ_W-1:0]  SRAM_DQ,
    output logic             init_busy,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count,
    output logic             contention
);
    cmd_e                 cmd_c;
    logic [ADDR_BITS-1:0] addr_c;

    state_e               state, state_nxt;
    logic [LAT_W-1:0]     lat_cnt, lat_cnt_nxt;
    logic [ADDR_BITS-1:0] rd_addr, rd_addr_nxt;
    logic [CNT_W-1:0]     rd_count_nxt, wr_count_nxt;
    logic                 contention_nxt;
    logic                 wr_last_vld, wr_last_vld_nxt;
    logic [ADDR_BITS-1:0] wr_last_addr, wr_last_addr_nxt;

    logic                 mem_we_c;
    logic [LANES-1:0]     mem_be_c;
    logic [MEM_BITS-1:0]  mem_waddr_c;
    logic [DQ_W-1:0]      mem_wdata_c;
    logic [DQ_W-1:0]      mem_rdata_c;
    logic                 drive_c;

    assign cmd_c  = decode_cmd(bus.SRAM_CE_N, bus.SRAM_WE_N, bus.SRAM_OE_N);
    assign addr_c = bus.SRAM_ADDR;

`ifdef SRAM_RESP_INIT_EN
    logic                init_pend, init_pend_nxt;
    logic [MEM_BITS-1:0] init_ptr, init_ptr_nxt;
    logic                init_busy_nxt;

    // Sweep bookkeeping; init_pend arms the sweep on reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_pend <= 1'b1;
            init_ptr  <= '0;
            init_busy <= 1'b0;
        end else begin
            init_pend <= init_pend_nxt;
            init_ptr  <= init_ptr_nxt;
            init_busy <= init_busy_nxt;
        end
    end
`else
    assign init_busy = 1'b0;
`endif

    // Array write port: bus writes, or the clear sweep when enabled.
    always_comb begin
        mem_we_c    = 1'b0;
        mem_be_c    = '0;
        mem_waddr_c = addr_c[MEM_BITS-1:0];
        mem_wdata_c = SRAM_DQ;
`ifdef SRAM_RESP_INIT_EN
        if (state == ST_INIT) begin
            mem_we_c    = 1'b1;
            mem_be_c    = '1;
            mem_waddr_c = init_ptr;
            mem_wdata_c = '0;
        end else if (!init_pend && cmd_c == CMD_WRITE) begin
`else
        if (cmd_c == CMD_WRITE) begin
`endif
            mem_we_c = 1'b1;
            mem_be_c = {~bus.SRAM_UB_N, ~bus.SRAM_LB_N};
        end
    end

    sram_resp_array #(
        .MEM_BITS (MEM_BITS)
    ) u_array (
        .clk     (clk),
        .we      (mem_we_c),
        .be      (mem_be_c),
        .waddr   (mem_waddr_c),
        .wdata   (mem_wdata_c),
        .raddr   (rd_addr[MEM_BITS-1:0]),
        .rdata_c (mem_rdata_c)
    );

    // Next-state, latency, counters and sticky contention flag.
    always_comb begin
        state_nxt        = state;
        lat_cnt_nxt      = lat_cnt;
        rd_addr_nxt      = rd_addr;
        rd_count_nxt     = rd_count;
        wr_count_nxt     = wr_count;
        contention_nxt   = contention;
        wr_last_vld_nxt  = 1'b0;
        wr_last_addr_nxt = wr_last_addr;
`ifdef SRAM_RESP_INIT_EN
        init_pend_nxt    = init_pend;
        init_ptr_nxt     = init_ptr;
        init_busy_nxt    = init_busy;

        if (init_pend) begin
            init_pend_nxt = 1'b0;
            init_ptr_nxt  = '0;
            init_busy_nxt = 1'b1;
            state_nxt     = ST_INIT;
        end else if (state == ST_INIT) begin
            init_ptr_nxt = init_ptr + MEM_BITS'(1);
            if (&init_ptr) begin
                init_busy_nxt = 1'b0;
                state_nxt     = ST_IDLE;
            end
        end else
`endif
        begin
            unique case (cmd_c)
                CMD_WRITE: begin
                    state_nxt        = ST_IDLE;
                    lat_cnt_nxt      = '0;
                    wr_last_vld_nxt  = 1'b1;
                    wr_last_addr_nxt = addr_c;
                    if (!wr_last_vld || addr_c != wr_last_addr) begin
                        wr_count_nxt = wr_count + CNT_W'(1);
                    end
                    if (!bus.SRAM_OE_N) begin
                        contention_nxt = 1'b1;
                    end
                end
                CMD_READ: begin
                    if (state == ST_IDLE || addr_c != rd_addr) begin
                        // New read or address change: (re)start the latency window.
                        rd_addr_nxt = addr_c;
                        if (WAIT_CYCLES == 0) begin
                            state_nxt    = ST_RD_DRIVE;
                            lat_cnt_nxt  = '0;
                            rd_count_nxt = rd_count + CNT_W'(1);
                        end else begin
                            state_nxt   = ST_RD_WAIT;
                            lat_cnt_nxt = LAT_W'(WAIT_CYCLES);
                        end
                    end else if (state == ST_RD_WAIT) begin
                        if (lat_cnt <= LAT_W'(1)) begin
                            state_nxt    = ST_RD_DRIVE;
                            lat_cnt_nxt  = '0;
                            rd_count_nxt = rd_count + CNT_W'(1);
                        end else begin
                            lat_cnt_nxt = lat_cnt - LAT_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt   = ST_IDLE;
                    lat_cnt_nxt = '0;
                end
            endcase
        end
    end

    // State and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            lat_cnt      <= '0;
            rd_addr      <= '0;
            rd_count     <= '0;
            wr_count     <= '0;
            contention   <= 1'b0;
            wr_last_vld  <= 1'b0;
            wr_last_addr <= '0;
        end else begin
            state        <= state_nxt;
            lat_cnt      <= lat_cnt_nxt;
            rd_addr      <= rd_addr_nxt;
            rd_count     <= rd_count_nxt;
            wr_count     <= wr_count_nxt;
            contention   <= contention_nxt;
            wr_last_vld  <= wr_last_vld_nxt;
            wr_last_addr <= wr_last_addr_nxt;
        end
    end

    // Drive is gated by the live strobes so DQ is released in the cycle the read ends.
    assign drive_c = (state == ST_RD_DRIVE) && !bus.SRAM_CE_N && !bus.SRAM_OE_N && bus.SRAM_WE_N;

    assign SRAM_DQ[15:8] = (drive_c && !bus.SRAM_UB_N) ? mem_rdata_c[15:8] : 8'hzz;
    assign SRAM_DQ[7:0]  = (drive_c && !bus.SRAM_LB_N) ? mem_rdata_c[7:0]  : 8'hzz;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder; DQ is pulled up so a released bus reads 16'hFFFF.
module tb_sram_responder;
    import sram_resp_pkg::*;

    localparam int unsigned ADDR_BITS   = 18;
`ifdef SRAM_RESP_INIT_EN
    localparam int unsigned MEM_BITS    = 4;
`else
    localparam int unsigned MEM_BITS    = 12;
`endif
    localparam int unsigned WAIT_CYCLES = 1;
    localparam logic [15:0] HIZ         = 16'hFFFF;
    localparam int          NVEC        = 11;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_busy;
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic        contention;
    logic        tb_oe;
    logic [15:0] tb_dq;
    wire  [15:0] dq;

    always #5 clk = ~clk;

    sram_responder_if #(.ADDR_BITS(ADDR_BITS)) bus ();

    assign dq = tb_oe ? tb_dq : 16'hzzzz;
    pullup (dq);

    sram_responder #(
        .ADDR_BITS   (ADDR_BITS),
        .MEM_BITS    (MEM_BITS),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .SRAM_DQ    (dq),
        .init_busy  (init_busy),
        .rd_count   (rd_count),
        .wr_count   (wr_count),
        .contention (contention)
    );

    typedef struct {
        bit          wr;
        logic [17:0] addr;
        logic [15:0] data;   // write data, or expected DQ for a read
        logic        ub_n;
        logic        lb_n;
    } vec_t;

    vec_t        tbl [NVEC];
    logic [15:0] exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] rd_exp = 16'd0;
    logic [15:0] wr_exp = 16'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_idle();
        bus.SRAM_CE_N = 1'b1;
        bus.SRAM_WE_N = 1'b1;
        bus.SRAM_OE_N = 1'b1;
        bus.SRAM_UB_N = 1'b0;
        bus.SRAM_LB_N = 1'b0;
        tb_oe         = 1'b0;
    endtask

    task automatic set_write(input logic [17:0] a, input logic [15:0] d, input logic ub, input logic lb);
        bus.SRAM_CE_N = 1'b0;
        bus.SRAM_WE_N = 1'b0;
        bus.SRAM_OE_N = 1'b1;
        bus.SRAM_ADDR = a;
        bus.SRAM_UB_N = ub;
        bus.SRAM_LB_N = lb;
        tb_dq         = d;
        tb_oe         = 1'b1;
    endtask

    task automatic set_read(input logic [17:0] a, input logic ub, input logic lb);
        bus.SRAM_CE_N = 1'b0;
        bus.SRAM_WE_N = 1'b1;
        bus.SRAM_OE_N = 1'b0;
        bus.SRAM_ADDR = a;
        bus.SRAM_UB_N = ub;
        bus.SRAM_LB_N = lb;
        tb_oe         = 1'b0;
    endtask

    task automatic do_write(input logic [17:0] a, input logic [15:0] d, input logic ub, input logic lb);
        set_write(a, d, ub, lb);
        @(negedge clk);
        set_idle();
        @(negedge clk);
        wr_exp = wr_exp + 16'd1;
    endtask

    // Wait for rd_count to move (the DUT starting to drive), checking DQ is released meanwhile.
    task automatic await_drive();
        logic [15:0] rc0;
        int          k;
        bit          got;
        rc0 = rd_count;
        k   = 0;
        got = 1'b0;
        while (!got && k < 16) begin
            @(negedge clk);
            k++;
            if (rd_count !== rc0) got = 1'b1;
            else check("hiz_during_wait", 32'(dq), 32'(HIZ));
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL rd_timeout: rd_count stuck at %h, required a change", rc0);
            void'(exp_q.pop_front());
        end else begin
            check("rd_latency", 32'(k), 32'(WAIT_CYCLES + 1));
            check("rd_data", 32'(dq), 32'(exp_q.pop_front()));
            rd_exp = rd_exp + 16'd1;
        end
    endtask

    task automatic do_read(input logic [17:0] a, input logic ub, input logic lb, input logic [15:0] e);
        set_read(a, ub, lb);
        exp_q.push_back(e);
        await_drive();
    endtask

    task automatic end_read();
        set_idle();
        #1;
        check("dq_release", 32'(dq), 32'(HIZ));
        @(negedge clk);
    endtask

`ifdef SRAM_RESP_INIT_EN
    task automatic init_seq();
        int busy_cycles;
        busy_cycles = 0;
        set_read(18'h00003, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (init_busy) busy_cycles++;
            else if (busy_cycles != 0) break;
        end
        set_idle();
        check("init_busy_len", 32'(busy_cycles), 32'd16);
        check("init_rd_ignored", 32'(rd_count), 32'd0);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b1, 18'h00010, 16'hBEEF, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 18'h00010, 16'hBEEF, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 18'h00005, 16'h1234, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 18'h00005, 16'hAB00, 1'b0, 1'b1};
        tbl[4]  = '{1'b0, 18'h00005, 16'hAB34, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 18'h01001, 16'h5A5A, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 18'h00001, 16'h5A5A, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 18'h00005, 16'hABFF, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 18'h00010, 16'hFFEF, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 18'h00777, 16'hC0DE, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 18'h00777, 16'hC0DE, 1'b0, 1'b0};

        set_idle();
        bus.SRAM_ADDR = '0;
        tb_dq         = 16'h0000;
        rst           = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rd_count", 32'(rd_count), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_contention", 32'(contention), 32'd0);
        check("rst_init_busy", 32'(init_busy), 32'd0);
        check("rst_dq", 32'(dq), 32'(HIZ));
        rst = 1'b1;
`ifdef SRAM_RESP_INIT_EN
        init_seq();
        do_read(18'h00007, 1'b0, 1'b0, 16'h0000);
        end_read();
        do_read(18'h3FFFF, 1'b0, 1'b0, 16'h0000);
        end_read();
`else
        @(negedge clk);
        check("init_busy_off", 32'(init_busy), 32'd0);
`endif

        // Table of writes and reads
        for (int i = 0; i < NVEC; i++) begin
            if (tbl[i].wr) begin
                do_write(tbl[i].addr, tbl[i].data, tbl[i].ub_n, tbl[i].lb_n);
            end else begin
                do_read(tbl[i].addr, tbl[i].ub_n, tbl[i].lb_n, tbl[i].data);
                end_read();
            end
        end
        check("tbl_wr_count", 32'(wr_count), 32'(wr_exp));
        check("tbl_rd_count", 32'(rd_count), 32'(rd_exp));

        // Address change while driving restarts latency
        do_read(18'h00010, 1'b0, 1'b0, 16'hBEEF);
        set_read(18'h00005, 1'b0, 1'b0);
        exp_q.push_back(16'hAB34);
        await_drive();
        end_read();
        check("addr_chg_rd_count", 32'(rd_count), 32'(rd_exp));

        // Read abandoned during the wait window is not counted
        set_read(18'h00005, 1'b0, 1'b0);
        @(negedge clk);
        set_idle();
        @(negedge clk);
        check("abandon_rd_count", 32'(rd_count), 32'(rd_exp));
        check("abandon_dq", 32'(dq), 32'(HIZ));

        // Consecutive writes to one address form a single transaction
        set_write(18'h00020, 16'h1111, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        set_write(18'h00020, 16'h2222, 1'b0, 1'b0);
        @(negedge clk);
        set_write(18'h00021, 16'h3333, 1'b0, 1'b0);
        @(negedge clk);
        set_idle();
        @(negedge clk);
        wr_exp = wr_exp + 16'd2;
        check("coalesce_wr_count", 32'(wr_count), 32'(wr_exp));
        do_read(18'h00020, 1'b0, 1'b0, 16'h2222);
        end_read();
        do_read(18'h00021, 1'b0, 1'b0, 16'h3333);
        end_read();

        // WE_N and OE_N low together: sticky flag, write still lands
        bus.SRAM_CE_N = 1'b0;
        bus.SRAM_WE_N = 1'b0;
        bus.SRAM_OE_N = 1'b0;
        bus.SRAM_ADDR = 18'h00030;
        tb_dq         = 16'h7777;
        tb_oe         = 1'b1;
        @(negedge clk);
        check("contention_set", 32'(contention), 32'd1);
        set_idle();
        wr_exp = wr_exp + 16'd1;
        #1;
        check("contention_dq", 32'(dq), 32'(HIZ));
        repeat (3) @(negedge clk);
        check("contention_sticky", 32'(contention), 32'd1);
        do_read(18'h00030, 1'b0, 1'b0, 16'h7777);
        end_read();
        check("contention_wr_count", 32'(wr_count), 32'(wr_exp));

        // Reset in the middle of a driven read
        do_read(18'h00030, 1'b0, 1'b0, 16'h7777);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_dq", 32'(dq), 32'(HIZ));
        check("rst_mid_rd_count", 32'(rd_count), 32'd0);
        check("rst_mid_wr_count", 32'(wr_count), 32'd0);
        check("rst_mid_contention", 32'(contention), 32'd0);
        @(negedge clk);
        set_idle();
        rst    = 1'b1;
        rd_exp = 16'd0;
        wr_exp = 16'd0;
`ifdef SRAM_RESP_INIT_EN
        init_seq();
        do_read(18'h00030, 1'b0, 1'b0, 16'h0000);
`else
        @(negedge clk);
        do_read(18'h00030, 1'b0, 1'b0, 16'h7777);
`endif
        end_read();
        check("final_rd_count", 32'(rd_count), 32'(rd_exp));
        check("final_wr_count", 32'(wr_count), 32'(wr_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
